// File: rtl/systolic_array_os_if.sv
// Operand/result handshake bundle for the output-stationary systolic engine.
// The producer/consumer side uses the master modport; the engine uses slave.
interface systolic_array_os_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 255
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                       start_i;
    logic [KW-1:0]              k_len_i;
    logic [ROWS*DATA_WIDTH-1:0] a_vec_i;
    logic [COLS*DATA_WIDTH-1:0] b_vec_i;
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [COLS*ACC_WIDTH-1:0]  res_o;
    logic [RW-1:0]              res_row_o;
    logic                       res_valid_o;
    logic                       res_ready_i;
    logic                       res_last_o;
    logic                       busy_o;
    logic                       done_o;

    modport master (
        output start_i, k_len_i, a_vec_i, b_vec_i, in_valid_i, res_ready_i,
        input  in_ready_o, res_o, res_row_o, res_valid_o, res_last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, k_len_i, a_vec_i, b_vec_i, in_valid_i, res_ready_i,
        output in_ready_o, res_o, res_row_o, res_valid_o, res_last_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic matrix multiply: C = A x B for a
// runtime K. Operands enter through skew registers (lane r / lane c delayed
// r / c cycles), each PE keeps its own accumulator, and finished rows are
// drained one per beat over a valid/ready handshake.
module systolic_array_os #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 255
) (
    input logic                 clk,
    input logic                 rstn,
    systolic_array_os_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [KW-1:0]       k_len_r, beat_cnt_r;
    logic [FW-1:0]       flush_cnt_r;
    logic                in_ready_r, res_valid_r, res_last_r, busy_r, done_r;
    logic [RW-1:0]       res_row_r, row_sel_s;
    logic [COLS*AW-1:0]  res_r, row_pack_s;

    logic start_acc_s, in_hs_s, out_hs_s, last_beat_s, flush_end_s, active_s;

    logic signed [DW-1:0] a_inj_s [ROWS];
    logic signed [DW-1:0] b_inj_s [COLS];
    logic signed [DW-1:0] a_in_s  [ROWS][COLS];
    logic signed [DW-1:0] b_in_s  [ROWS][COLS];
    logic signed [AW-1:0] acc_s   [ROWS][COLS];

    assign start_acc_s = (state_r == IDLE) && bus.start_i;
    assign in_hs_s     = bus.in_valid_i && in_ready_r;
    assign out_hs_s    = res_valid_r && bus.res_ready_i;
    assign last_beat_s = in_hs_s && ((beat_cnt_r + KW'(1)) == k_len_r);
    assign flush_end_s = (flush_cnt_r == FW'(ROWS + COLS - 2));
    assign active_s    = (state_r != IDLE);

    // Next-state logic of the tile sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.k_len_i != KW'(0)) state_nxt_s = FEED;
                    else                       state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FEED: begin
                if (last_beat_s) state_nxt_s = FLUSH;
                else             state_nxt_s = FEED;
            end
            FLUSH: begin
                if (flush_end_s) state_nxt_s = DRAIN;
                else             state_nxt_s = FLUSH;
            end
            DRAIN: begin
                if (out_hs_s && res_last_r) state_nxt_s = IDLE;
                else                        state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Tile length latch, operand beat counter and flush counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_len_r     <= KW'(0);
            beat_cnt_r  <= KW'(0);
            flush_cnt_r <= FW'(0);
        end else if (start_acc_s) begin
            k_len_r     <= bus.k_len_i;
            beat_cnt_r  <= KW'(0);
            flush_cnt_r <= FW'(0);
        end else begin
            if (in_hs_s)           beat_cnt_r  <= beat_cnt_r + KW'(1);
            if (state_r == FLUSH)  flush_cnt_r <= flush_cnt_r + FW'(1);
        end
    end

    // Accepted operands enter the array; any other cycle injects zeros.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            a_inj_s[r] = in_hs_s ? bus.a_vec_i[r*DW +: DW] : DW'(0);
        for (int c = 0; c < COLS; c++)
            b_inj_s[c] = in_hs_s ? bus.b_vec_i[c*DW +: DW] : DW'(0);
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
        if (gr == 0) begin : g_direct
            assign a_in_s[0][0] = a_inj_s[0];
        end else begin : g_delay
            logic signed [DW-1:0] sh_r [gr];
            // A lane delay line of gr stages.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int d = 0; d < gr; d++) sh_r[d] <= DW'(0);
                end else if (start_acc_s) begin
                    for (int d = 0; d < gr; d++) sh_r[d] <= DW'(0);
                end else begin
                    sh_r[0] <= a_inj_s[gr];
                    for (int d = 1; d < gr; d++) sh_r[d] <= sh_r[d-1];
                end
            end
            assign a_in_s[gr][0] = sh_r[gr-1];
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
        if (gc == 0) begin : g_direct
            assign b_in_s[0][0] = b_inj_s[0];
        end else begin : g_delay
            logic signed [DW-1:0] sh_r [gc];
            // B lane delay line of gc stages.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int d = 0; d < gc; d++) sh_r[d] <= DW'(0);
                end else if (start_acc_s) begin
                    for (int d = 0; d < gc; d++) sh_r[d] <= DW'(0);
                end else begin
                    sh_r[0] <= b_inj_s[gc];
                    for (int d = 1; d < gc; d++) sh_r[d] <= sh_r[d-1];
                end
            end
            assign b_in_s[0][gc] = sh_r[gc-1];
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_pe
            logic signed [AW-1:0]   acc_r;
            logic signed [2*DW-1:0] prod_s;

            assign prod_s          = a_in_s[gr][gc] * b_in_s[gr][gc];
            assign acc_s[gr][gc]   = acc_r;

            // Accumulate the sign-extended full-precision product; wraps on overflow.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)            acc_r <= AW'(0);
                else if (start_acc_s) acc_r <= AW'(0);
                else if (active_s)    acc_r <= acc_r + AW'(prod_s);
                else                  acc_r <= acc_r;
            end

            if (gc < COLS - 1) begin : g_afwd
                logic signed [DW-1:0] a_fwd_r;
                // Pass the A operand to the right-hand neighbour.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn)            a_fwd_r <= DW'(0);
                    else if (start_acc_s) a_fwd_r <= DW'(0);
                    else                  a_fwd_r <= a_in_s[gr][gc];
                end
                assign a_in_s[gr][gc+1] = a_fwd_r;
            end

            if (gr < ROWS - 1) begin : g_bfwd
                logic signed [DW-1:0] b_fwd_r;
                // Pass the B operand to the neighbour below.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn)            b_fwd_r <= DW'(0);
                    else if (start_acc_s) b_fwd_r <= DW'(0);
                    else                  b_fwd_r <= b_in_s[gr][gc];
                end
                assign b_in_s[gr+1][gc] = b_fwd_r;
            end
        end
    end

    // Select the accumulator row that the next drain beat will present.
    always_comb begin
        row_sel_s = (state_r == DRAIN) ? (res_row_r + RW'(1)) : RW'(0);
        for (int c = 0; c < COLS; c++)
            row_pack_s[c*AW +: AW] = acc_s[row_sel_s][c];
    end

    // Registered status flags and row-serial result drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            res_row_r   <= RW'(0);
            res_r       <= '0;
        end else begin
            in_ready_r <= (state_nxt_s == FEED);
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= out_hs_s && res_last_r;
            if ((state_r != DRAIN) && (state_nxt_s == DRAIN)) begin
                // K = 0 goes straight here while the accumulators clear.
                res_valid_r <= 1'b1;
                res_row_r   <= RW'(0);
                res_last_r  <= (ROWS == 1) ? 1'b1 : 1'b0;
                res_r       <= start_acc_s ? '0 : row_pack_s;
            end else if (out_hs_s) begin
                if (res_last_r) begin
                    res_valid_r <= 1'b0;
                    res_row_r   <= RW'(0);
                    res_last_r  <= 1'b0;
                    res_r       <= '0;
                end else begin
                    res_row_r   <= res_row_r + RW'(1);
                    res_last_r  <= ((res_row_r + RW'(1)) == RW'(ROWS - 1));
                    res_r       <= row_pack_s;
                end
            end else begin
                res_valid_r <= res_valid_r;
                res_row_r   <= res_row_r;
                res_last_r  <= res_last_r;
                res_r       <= res_r;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.res_valid_o = res_valid_r;
    assign bus.res_row_o   = res_row_r;
    assign bus.res_last_o  = res_last_r;
    assign bus.res_o       = res_r;
endmodule
